fifo_rd_stream: RTL and testbench

//   Read-side adapter for the team FIFO. Drives FIFO RD_EN, captures FIFO DOUT
//   one cycle after each accepted read, and presents the data as a valid/ready

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_rd_out_buf.sv | 59 +++++
 rtl/fifo_rd_stream.sv | 80 ++++++++
 tb/tb_fifo_rd_stream.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for FIFO users: buffer occupancy type and
// the read-issue space check used by stream adapters.
package fifo_pkg;

  // Buffer occupancy, legal range 0..OCC_MAX
  typedef logic [1:0] occ_t;

  localparam occ_t OCC_MAX = 2'd2;

  // A new read may issue if the words already held plus the word in flight
  // leave a free slot, counting a slot freed by this cycle's pop.
  function automatic logic calc_space(occ_t occ, logic pend, logic pop);
    logic [2:0] sum;
    sum = {1'b0, occ} + {2'b00, pend};
    return (sum <= 3'd1) || ((sum == {1'b0, OCC_MAX}) && pop);
  endfunction

endpackage

// File: rtl/fifo_rd_out_buf.sv
// Two-entry shift buffer: entry 0 is the head. A pop shifts entry 1 down
// on the same edge that a push writes the new tail.
module fifo_rd_out_buf
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output occ_t                  occ_o
);

  logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
  logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
  occ_t                  occ_q, occ_d;
  occ_t                  occ_after_pop;
  logic                  pop_ok;

  // Next-state: shift on pop, then write the tail slot left after the pop
  always_comb begin
    ent0_d        = ent0_q;
    ent1_d        = ent1_q;
    pop_ok        = pop_i && (occ_q != 2'd0);
    occ_after_pop = occ_q - occ_t'(pop_ok);
    if (pop_ok) begin
      ent0_d = ent1_q;
      ent1_d = '0;
    end
    if (push_i) begin
      if (occ_after_pop == 2'd0) begin
        ent0_d = push_data_i;
      end else begin
        ent1_d = push_data_i;
      end
    end
    occ_d = occ_after_pop + occ_t'(push_i);
  end

  // Buffer state registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= '0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
    end
  end

  assign data_o = ent0_q;
  assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter: issues FIFO reads, captures FIFO_DOUT one cycle later
// and presents words as a valid/ready stream through a 2-entry buffer.
// Optional feature macro: FIFO_RD_STREAM_CNT_EN enables the saturating
// XFER_CNT delivered-word counter; otherwise XFER_CNT is tied to 0.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  ENABLE,
  input  logic                  FIFO_EMPTY,
  input  logic                  FIFO_WR_EN,
  input  logic [DATA_WIDTH-1:0] FIFO_DOUT,
  output logic                  FIFO_RD_EN,
  output logic                  M_VALID,
  output logic [DATA_WIDTH-1:0] M_DATA,
  input  logic                  M_READY,
  output logic [CNT_WIDTH-1:0]  XFER_CNT
);

  logic pend_q;
  logic pop;
  occ_t occ;

  assign M_VALID = (occ != 2'd0);
  assign pop     = M_VALID && M_READY;

  // The FIFO ignores RD_EN while WR_EN is high, so never issue then
  assign FIFO_RD_EN = ENABLE && !FIFO_EMPTY && !FIFO_WR_EN && calc_space(occ, pend_q, pop);

  // Marks the cycle in which FIFO_DOUT holds data from an accepted read
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= FIFO_RD_EN;
    end
  end

  fifo_rd_out_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_buf (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .push_i      (pend_q),
    .push_data_i (FIFO_DOUT),
    .pop_i       (pop),
    .data_o      (M_DATA),
    .occ_o       (occ)
  );

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Count delivered words, holding at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (pop && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // Transfer counter register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign XFER_CNT = cnt_q;
`else
  assign XFER_CNT = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream with a behavioural FIFO model.
module tb_fifo_rd_stream;

  localparam int unsigned DW    = 8;
  localparam int unsigned CNT_W = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          ENABLE = 1'b0;
  logic          FIFO_EMPTY = 1'b1;
  logic          FIFO_WR_EN = 1'b0;
  logic [DW-1:0] FIFO_DOUT = '0;
  logic          FIFO_RD_EN;
  logic          M_VALID;
  logic [DW-1:0] M_DATA;
  logic          M_READY = 1'b0;
  logic [CNT_W-1:0] XFER_CNT;

  fifo_rd_stream #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CNT_W)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .ENABLE     (ENABLE),
    .FIFO_EMPTY (FIFO_EMPTY),
    .FIFO_WR_EN (FIFO_WR_EN),
    .FIFO_DOUT  (FIFO_DOUT),
    .FIFO_RD_EN (FIFO_RD_EN),
    .M_VALID    (M_VALID),
    .M_DATA     (M_DATA),
    .M_READY    (M_READY),
    .XFER_CNT   (XFER_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic          en;
    logic          rdy;
    logic          wr;
    logic [DW-1:0] wdata;
    logic          exp_rd;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t          vecs[13];
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] got[$];
  int            n_checks = 0;
  int            n_fail = 0;

  function automatic int exp_cnt(int pops);
`ifdef FIFO_RD_STREAM_CNT_EN
    return (pops > 15) ? 15 : pops;
`else
    return 0 * pops;
`endif
  endfunction

  task automatic chk(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // One clock: sample the FIFO handshake before the edge, update the model after it
  task automatic tick();
    logic rd, wr;
    #1;
    rd = FIFO_RD_EN;
    wr = FIFO_WR_EN;
    @(posedge CLK);
    #1;
    if (rd && fifo_q.size() > 0) FIFO_DOUT = fifo_q.pop_front();
    else                         FIFO_DOUT = '0;
    if (wr) fifo_q.push_back(wr_data);
    FIFO_EMPTY = (fifo_q.size() == 0);
  endtask

  task automatic do_reset();
    RST_N      = 1'b0;
    ENABLE     = 1'b0;
    M_READY    = 1'b0;
    FIFO_WR_EN = 1'b0;
    fifo_q.delete();
    FIFO_DOUT  = '0;
    FIFO_EMPTY = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  task automatic preload(input int n, input int base);
    for (int i = 0; i < n; i++) fifo_q.push_back(DW'(base + i));
    FIFO_EMPTY = (fifo_q.size() == 0);
  endtask

  task automatic apply_vec(input int i);
    ENABLE     = vecs[i].en;
    M_READY    = vecs[i].rdy;
    FIFO_WR_EN = vecs[i].wr;
    wr_data    = vecs[i].wdata;
    #1;
    chk($sformatf("vec%0d rd_en", i), int'(FIFO_RD_EN), int'(vecs[i].exp_rd));
    chk($sformatf("vec%0d m_valid", i), int'(M_VALID), int'(vecs[i].exp_valid));
    if (vecs[i].exp_valid) chk($sformatf("vec%0d m_data", i), int'(M_DATA), int'(vecs[i].exp_data));
    tick();
  endtask

  initial begin
    int rdcount;
    int pops;

    // Basic 3-word flow from reset
    vecs[0]  = '{1, 1, 0, 8'h00, 1, 0, 8'h00};
    vecs[1]  = '{1, 1, 0, 8'h00, 1, 0, 8'h00};
    vecs[2]  = '{1, 1, 0, 8'h00, 1, 1, 8'h11};
    vecs[3]  = '{1, 1, 0, 8'h00, 0, 1, 8'h22};
    vecs[4]  = '{1, 1, 0, 8'h00, 0, 1, 8'h33};
    vecs[5]  = '{1, 1, 0, 8'h00, 0, 0, 8'h00};
    // FIFO_WR_EN blocks the first read for one cycle
    vecs[6]  = '{1, 1, 1, 8'hA3, 0, 0, 8'h00};
    vecs[7]  = '{1, 1, 0, 8'h00, 1, 0, 8'h00};
    vecs[8]  = '{1, 1, 0, 8'h00, 1, 0, 8'h00};
    vecs[9]  = '{1, 1, 0, 8'h00, 1, 1, 8'hA1};
    vecs[10] = '{1, 1, 0, 8'h00, 0, 1, 8'hA2};
    vecs[11] = '{1, 1, 0, 8'h00, 0, 1, 8'hA3};
    vecs[12] = '{1, 1, 0, 8'h00, 0, 0, 8'h00};

    // Test 1: reset state, then 3-word stream
    do_reset();
    #1;
    chk("reset m_valid", int'(M_VALID), 0);
    chk("reset m_data", int'(M_DATA), 0);
    chk("reset xfer_cnt", int'(XFER_CNT), 0);
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    fifo_q.push_back(8'h33);
    FIFO_EMPTY = 1'b0;
    for (int i = 0; i <= 5; i++) apply_vec(i);
    #1;
    chk("t1 xfer_cnt", int'(XFER_CNT), exp_cnt(3));

    // Test 3: write collision
    do_reset();
    fifo_q.push_back(8'hA1);
    fifo_q.push_back(8'hA2);
    FIFO_EMPTY = 1'b0;
    for (int i = 6; i <= 12; i++) apply_vec(i);

    // Test 2: back-pressure with 5 words
    do_reset();
    preload(5, 1);
    ENABLE  = 1'b1;
    M_READY = 1'b0;
    rdcount = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (FIFO_RD_EN) rdcount++;
      if (M_VALID) chk("t2 hold m_data", int'(M_DATA), 1);
      tick();
    end
    chk("t2 reads issued", rdcount, 2);
    #1;
    chk("t2 stalled rd_en", int'(FIFO_RD_EN), 0);
    chk("t2 stalled m_valid", int'(M_VALID), 1);
    chk("t2 stalled m_data", int'(M_DATA), 1);
    M_READY = 1'b1;
    got.delete();
    for (int c = 0; c < 20; c++) begin
      #1;
      if (M_VALID) got.push_back(M_DATA);
      tick();
    end
    chk("t2 word count", got.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) chk($sformatf("t2 word%0d", i), int'(got[i]), i + 1);
    end
    #1;
    chk("t2 xfer_cnt", int'(XFER_CNT), exp_cnt(5));

    // Test 4: ENABLE dropped the cycle after a read issues
    do_reset();
    fifo_q.push_back(8'h5A);
    fifo_q.push_back(8'h5B);
    FIFO_EMPTY = 1'b0;
    ENABLE  = 1'b1;
    M_READY = 1'b1;
    #1;
    chk("t4 first rd_en", int'(FIFO_RD_EN), 1);
    tick();
    ENABLE = 1'b0;
    #1;
    chk("t4 rd_en after drop", int'(FIFO_RD_EN), 0);
    tick();
    #1;
    chk("t4 m_valid", int'(M_VALID), 1);
    chk("t4 m_data", int'(M_DATA), 8'h5A);
    rdcount = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (FIFO_RD_EN) rdcount++;
      tick();
    end
    chk("t4 extra reads", rdcount, 0);
    chk("t4 drained", int'(M_VALID), 0);

    // Test 5: async reset while full with a read being accepted
    do_reset();
    preload(4, 8'h41);
    ENABLE  = 1'b1;
    M_READY = 1'b0;
    repeat (3) tick();
    M_READY = 1'b1;
    #1;
    chk("t5 full m_valid", int'(M_VALID), 1);
    chk("t5 full rd_en", int'(FIFO_RD_EN), 1);
    #1;
    RST_N = 1'b0;
    #1;
    chk("t5 async m_valid", int'(M_VALID), 0);
    chk("t5 async m_data", int'(M_DATA), 0);
    ENABLE = 1'b0;
    fifo_q.delete();
    FIFO_DOUT  = '0;
    FIFO_EMPTY = 1'b1;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    tick();
    #1;
    chk("t5 post xfer_cnt", int'(XFER_CNT), 0);
    chk("t5 post m_valid", int'(M_VALID), 0);

    // Test 6: counter saturation over 20 pops
    do_reset();
    preload(20, 1);
    ENABLE  = 1'b1;
    M_READY = 1'b1;
    pops = 0;
    for (int c = 0; c < 60 && pops < 20; c++) begin
      #1;
      if (M_VALID && M_READY) pops++;
      tick();
    end
    chk("t6 pops", pops, 20);
    #1;
    chk("t6 xfer_cnt", int'(XFER_CNT), exp_cnt(20));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
